// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_rr
//  Purpose  : N-channel valid/ready stream multiplexer with a registered
//             output. Fixed-select mode uses sel; round-robin mode arbitrates
//             fairly and locks the grant for the length of a packet.
//  Revision : 1.0  initial release
// ============================================================================
module stream_mux_rr #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH-1:0]        in_last,
   output logic [NUM_CH-1:0]        in_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_last,
   output logic [SEL_W-1:0]         out_ch,
   output logic                     out_valid,
   input  logic                     out_ready
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   localparam logic [SEL_W:0] c_one   = (SEL_W+1)'(1);
   localparam logic [SEL_W:0] c_nch   = (SEL_W+1)'(NUM_CH);
   localparam logic [SEL_W-1:0] c_ptr_rst = SEL_W'(NUM_CH - 1);

   state_t              r_state;
   logic [SEL_W-1:0]    r_lock_ch;
   logic [SEL_W-1:0]    r_ptr;
   logic [DATA_W-1:0]   r_out_data;
   logic                r_out_last;
   logic [SEL_W-1:0]    r_out_ch;
   logic                r_out_valid;

   logic                w_ld;
   logic                w_xfer;
   logic [SEL_W-1:0]    w_cand;
   logic                w_gvalid;
   logic [DATA_W-1:0]   w_data;
   logic                w_last;
   logic [2*NUM_CH-1:0] w_shift;
   logic [NUM_CH-1:0]   w_rot;
   logic [SEL_W-1:0]    w_off;
   logic [SEL_W:0]      w_sum;
   logic [SEL_W-1:0]    w_rr_ch;
   logic                w_rr_any;

   assign w_ld   = !r_out_valid || out_ready;
   assign w_xfer = w_ld && w_gvalid && !reset;

   // Round-robin search: rotate valids so bit 0 is the channel after ptr,
   // then take the lowest set bit and map it back to a channel index.
   always_comb begin
      w_shift  = {in_valid, in_valid} >> ({1'b0, r_ptr} + c_one);
      w_rot    = w_shift[NUM_CH-1:0];
      w_rr_any = |w_rot;
      w_off    = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (w_rot[k]) w_off = SEL_W'(k);
      end
      w_sum = {1'b0, r_ptr} + c_one + {1'b0, w_off};
      if (w_sum >= c_nch) w_sum = w_sum - c_nch;
      w_rr_ch = w_sum[SEL_W-1:0];
   end

   // Grant selection for the current mode and lock state.
   always_comb begin
      w_cand   = '0;
      w_gvalid = 1'b0;
      if (!mode) begin
         w_cand = sel;
         for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) w_gvalid = 1'b1;
         end
      end else if (r_state == ST_LOCKED) begin
         w_cand = r_lock_ch;
         for (int i = 0; i < NUM_CH; i++) begin
            if (r_lock_ch == SEL_W'(i) && in_valid[i]) w_gvalid = 1'b1;
         end
      end else begin
         w_cand   = w_rr_ch;
         w_gvalid = w_rr_any;
      end
   end

   // Route the granted channel's beat and drive its ready.
   always_comb begin
      w_data   = '0;
      w_last   = 1'b0;
      in_ready = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_cand == SEL_W'(i)) begin
            w_data      = in_data[i*DATA_W +: DATA_W];
            w_last      = in_last[i];
            in_ready[i] = w_xfer;
         end
      end
   end

   // Output register, round-robin pointer and packet-lock FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_ch    <= '0;
         r_out_valid <= 1'b0;
         r_ptr       <= c_ptr_rst;
         r_state     <= ST_IDLE;
         r_lock_ch   <= '0;
      end else begin
         if (w_xfer) begin
            r_out_data  <= w_data;
            r_out_last  <= w_last;
            r_out_ch    <= w_cand;
            r_out_valid <= 1'b1;
            r_ptr       <= w_cand;
         end else if (w_ld) begin
            r_out_valid <= 1'b0;
         end

         if (!mode) begin
            r_state <= ST_IDLE;
         end else if (w_xfer) begin
            if (w_last) begin
               r_state <= ST_IDLE;
            end else begin
               r_state   <= ST_LOCKED;
               r_lock_ch <= w_cand;
            end
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign out_ch    = r_out_ch;
   assign out_valid = r_out_valid;

endmodule
`default_nettype wire
